// File: rtl/async_req_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter for active-low asynchronous request pins: per-line
// two-flop synchronizers, hold-until-release grants and a watchdog timeout.
module async_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] async_req_n,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned N     = NUM_REQ;
  localparam int          CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [NUM_REQ-1:0] ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t             r_state, w_state_nx;
  logic [NUM_REQ-1:0] r_sync1, r_sync2, r_lockout, r_grant;
  logic [NUM_REQ-1:0] w_req, w_elig, w_grant_nx, w_lock_set;
  logic [IDX_W-1:0]   r_idx, r_rr_ptr, w_idx_nx, w_rr_nx, w_pick, w_idx_inc;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic               r_timeout, w_timeout_nx, w_found;

  // Modular increment that stays legal for non-power-of-2 NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  assign w_req     = ~r_sync2;
  assign w_elig    = w_req & ~r_lockout;
  assign w_idx_inc = wrap_add(r_idx, 1);

  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && w_elig[wrap_add(r_rr_ptr, i)]) begin
        w_pick  = wrap_add(r_rr_ptr, i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_idx_nx     = r_idx;
    w_cnt_nx     = r_cnt;
    w_rr_nx      = r_rr_ptr;
    w_timeout_nx = 1'b0;
    w_lock_set   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nx = ONE << w_pick;
          w_idx_nx   = w_pick;
          w_cnt_nx   = '0;
          w_state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
        w_cnt_nx = r_cnt + 1'b1;
        // Release wins over a coincident timeout: no pulse, no lockout.
        if (!w_req[r_idx]) begin
          w_grant_nx = '0;
          w_rr_nx    = w_idx_inc;
          w_state_nx = S_GAP;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_grant_nx        = '0;
          w_rr_nx           = w_idx_inc;
          w_timeout_nx      = 1'b1;
          w_lock_set[r_idx] = 1'b1;
          w_state_nx        = S_GAP;
        end
      end
      S_GAP:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_lockout <= '0;
      r_grant   <= '0;
      r_idx     <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_state   <= S_IDLE;
    end else begin
      r_sync1   <= async_req_n;
      r_sync2   <= r_sync1;
      r_lockout <= (r_lockout & w_req) | w_lock_set;
      r_grant   <= w_grant_nx;
      r_idx     <= w_idx_nx;
      r_rr_ptr  <= w_rr_nx;
      r_cnt     <= w_cnt_nx;
      r_timeout <= w_timeout_nx;
      r_state   <= w_state_nx;
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign timeout   = r_timeout;

endmodule
